// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// ----------------
// Sequencer and port arbiter for a 256 x 32-bit synchronous instruction RAM.
// In IDLE the CPU fetch address passes straight to the RAM, and the RAM read
// data passes straight back to the CPU. A load_start request stalls the CPU
// and takes over the RAM write port. The block then receives a byte-stream
// program, writes it, and checks it:
//   count byte N (0 means 256), 4N data bytes (MSB of each word first),
//   and one checksum byte (the XOR of all data bytes).
//
// Ports
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   cpu_address      CPU fetch address
//   cpu_instruction  fetched instruction, NOP (0) whenever not IDLE
//   cpu_stall        high while a load runs or after a failed load
//   load_start       single-cycle load request (IDLE / ERROR only)
//   load_data        stream byte
//   load_valid       load_data valid
//   load_ready       byte accepted when load_valid && load_ready
//   load_done        one-cycle pulse on the first IDLE cycle after a good load
//   load_error       level, set on checksum mismatch, cleared by load_start
//   mem_address      RAM address (CPU in IDLE, loader otherwise)
//   mem_wdata        RAM write data
//   mem_we           RAM write strobe, one cycle per word
//   mem_rdata        RAM read data, one cycle after mem_address
module instr_mem_loader #(
  parameter logic [7:0] BASE_ADDR = 8'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  cpu_address,
  output logic [31:0] cpu_instruction,
  output logic        cpu_stall,
  input  logic        load_start,
  input  logic [7:0]  load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        load_done,
  output logic        load_error,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_ERROR
  } state_e;

  state_e      state_q,  state_d;
  logic [7:0]  waddr_q,  waddr_d;   // next RAM address to write
  logic [8:0]  remain_q, remain_d;  // words still to write, up to 256
  logic [7:0]  acc_q,    acc_d;     // running XOR of data bytes
  logic [31:0] word_q,   word_d;    // word being assembled, MSB first
  logic [1:0]  bidx_q,   bidx_d;    // bytes of the current word received
  logic        done_q,   done_d;
  logic        error_q,  error_d;

  logic        xfer;

  assign xfer       = load_valid && load_ready;
  assign mem_wdata  = word_q;
  assign load_done  = done_q;
  assign load_error = error_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      remain_q <= '0;
      acc_q    <= '0;
      word_q   <= '0;
      bidx_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      remain_q <= remain_d;
      acc_q    <= acc_d;
      word_q   <= word_d;
      bidx_q   <= bidx_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    remain_d = remain_q;
    acc_d    = acc_q;
    word_d   = word_q;
    bidx_d   = bidx_q;
    done_d   = 1'b0;
    error_d  = error_q;

    // Loader owns the RAM port and the CPU sees NOPs everywhere but IDLE.
    cpu_stall       = 1'b1;
    cpu_instruction = '0;
    mem_address     = waddr_q;
    mem_we          = 1'b0;
    load_ready      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cpu_stall       = 1'b0;
        mem_address     = cpu_address;
        cpu_instruction = mem_rdata;
        if (load_start) begin
          error_d = 1'b0;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        load_ready = 1'b1;
        if (xfer) begin
          // A count byte of zero encodes a full 256-word image.
          remain_d = (load_data == 8'd0) ? 9'd256 : {1'b0, load_data};
          waddr_d  = BASE_ADDR;
          acc_d    = '0;
          bidx_d   = '0;
          state_d  = S_DATA;
        end
      end

      S_DATA: begin
        load_ready = 1'b1;
        if (xfer) begin
          word_d = {word_q[23:0], load_data};
          acc_d  = acc_q ^ load_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        mem_we   = 1'b1;
        waddr_d  = waddr_q + 8'd1;
        remain_d = remain_q - 9'd1;
        state_d  = (remain_q == 9'd1) ? S_CHECK : S_DATA;
      end

      S_CHECK: begin
        load_ready = 1'b1;
        if (xfer) begin
          if (load_data == acc_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end
        end
      end

      S_ERROR: begin
        if (load_start) begin
          error_d = 1'b0;
          state_d = S_COUNT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

  localparam logic [7:0] BASE = 8'd200;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  cpu_address;
  logic [31:0] cpu_instruction;
  logic        cpu_stall;
  logic        load_start;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        load_error;
  logic [7:0]  mem_address;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] ram     [256];
  logic [31:0] exp_mem [256];

  logic [7:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [7:0]  acc_bytes [$];
  int unsigned rdy_in_write   = 0;
  int unsigned instr_nz_stall = 0;
  int unsigned done_cnt       = 0;

  always #5 clock = ~clock;

  instr_mem_loader #(.BASE_ADDR(BASE)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpu_address    (cpu_address),
    .cpu_instruction(cpu_instruction),
    .cpu_stall      (cpu_stall),
    .load_start     (load_start),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_done      (load_done),
    .load_error     (load_error),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_rdata      (mem_rdata)
  );

  // Synchronous RAM
  always @(posedge clock) begin
    mem_rdata <= ram[mem_address];
    if (mem_we) ram[mem_address] <= mem_wdata;
  end

  // Activity log
  always @(posedge clock) begin
    if (mem_we) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_wdata);
      if (load_ready) rdy_in_write++;
    end
    if (load_valid && load_ready) acc_bytes.push_back(load_data);
    if (cpu_stall && cpu_instruction !== 32'd0) instr_nz_stall++;
    if (load_done) done_cnt++;
  end

  task automatic clear_log;
    wr_addr.delete();
    wr_data.delete();
    acc_bytes.delete();
    done_cnt = 0;
  endtask

  // Reference model: stream image of a program and the writes it implies.
  task automatic build_stream(input logic [31:0] words[$], input bit corrupt,
                              output logic [7:0] s[$], output bit good);
    logic [7:0] chk;
    chk = 8'd0;
    s.delete();
    s.push_back(8'(words.size()));  // 256 truncates to 0
    foreach (words[i]) begin
      for (int b = 3; b >= 0; b--) begin
        s.push_back(8'(words[i] >> (8 * b)));
        chk = chk ^ 8'(words[i] >> (8 * b));
      end
      exp_mem[8'(int'(BASE) + i)] = words[i];
    end
    s.push_back(corrupt ? ~chk : chk);
    good = !corrupt;
  endtask

  task automatic pulse_start;
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  // Offers s[0 .. stop_after-1]; ok reports all were consumed within budget.
  task automatic send(input logic [7:0] s[$], input bit gaps, input bit poke,
                      input int stop_after, output bit ok);
    int idx;
    int budget;
    bit rdy;
    idx = 0;
    budget = 0;
    while (idx < stop_after && budget < 20000) begin
      rdy        = load_ready;
      load_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      load_data  = load_valid ? s[idx] : 8'($urandom);
      load_start = poke && idx > 0 && ($urandom_range(0, 3) == 0);
      @(posedge clock); #1;
      if (load_valid && rdy) idx++;
      budget++;
    end
    load_valid = 1'b0;
    load_start = 1'b0;
    ok = (idx == stop_after);
  endtask

  task automatic test_reset;
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", load_ready); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", load_done); end
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got %b want 0", load_error); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we); end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
  endtask

  task automatic test_fetch;
    logic [7:0] a;
    cpu_address = 8'd5;
    @(posedge clock); #1;
    n_checks++; if (cpu_instruction !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch5 got %h want deadbeef", cpu_instruction); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall got %b want 0", cpu_stall); end
    n_checks++; if (mem_address !== 8'd5) begin n_fail++; $display("FAIL fetch_addr got %h want 05", mem_address); end
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      cpu_address = a;
      @(posedge clock); #1;
      n_checks++; if (cpu_instruction !== exp_mem[a]) begin n_fail++; $display("FAIL fetch_rand[%0h] got %h want %h", a, cpu_instruction, exp_mem[a]); end
    end
  endtask

  task automatic test_single_word;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    bit good, ok;
    w = '{32'h12345678};
    build_stream(w, 1'b0, s, good);
    n_checks++; if (s[5] !== 8'h08) begin n_fail++; $display("FAIL single_model_chk got %h want 08", s[5]); end
    clear_log();
    pulse_start();
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL single_stall_rise got %b want 1", cpu_stall); end
    send(s, 1'b0, 1'b0, s.size(), ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout got %0d want 1", ok); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL single_done got %b want 1", load_done); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL single_stall_fall got %b want 0", cpu_stall); end
    n_checks++; if (wr_addr.size() != 1) begin n_fail++; $display("FAIL single_nwrites got %0d want 1", wr_addr.size()); end
    else begin
      n_checks++; if (wr_addr[0] !== BASE) begin n_fail++; $display("FAIL single_waddr got %h want %h", wr_addr[0], BASE); end
      n_checks++; if (wr_data[0] !== 32'h12345678) begin n_fail++; $display("FAIL single_wdata got %h want 12345678", wr_data[0]); end
    end
    cpu_address = BASE;
    @(posedge clock); #1;
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL single_done_width got %b want 0", load_done); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL single_done_cnt got %0d want 1", done_cnt); end
    n_checks++; if (cpu_instruction !== 32'h12345678) begin n_fail++; $display("FAIL single_refetch got %h want 12345678", cpu_instruction); end
  endtask

  task automatic test_full_load;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    bit good, ok;
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    build_stream(w, 1'b0, s, good);
    clear_log();
    pulse_start();
    send(s, 1'b0, 1'b0, s.size(), ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout got %0d want 1", ok); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL full_done got %b want 1", load_done); end
    n_checks++; if (wr_addr.size() != 256) begin n_fail++; $display("FAIL full_nwrites got %0d want 256", wr_addr.size()); end
    for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
      n_checks++; if (wr_addr[i] !== 8'(int'(BASE) + i) || wr_data[i] !== w[i]) begin
        n_fail++; $display("FAIL full_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], 8'(int'(BASE) + i), w[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cpu_address = 8'($urandom);
      @(posedge clock); #1;
      n_checks++; if (cpu_instruction !== exp_mem[cpu_address]) begin n_fail++; $display("FAIL full_fetch[%0h] got %h want %h", cpu_address, cpu_instruction, exp_mem[cpu_address]); end
    end
  endtask

  task automatic test_bad_checksum;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    bit good, ok;
    w = '{32'hAABBCCDD};
    build_stream(w, 1'b1, s, good);
    clear_log();
    pulse_start();
    send(s, 1'b0, 1'b0, s.size(), ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bad_timeout got %0d want 1", ok); end
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL bad_error got %b want 1", load_error); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL bad_done got %b want 0", load_done); end
    n_checks++; if (wr_data.size() != 1 || wr_data[0] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL bad_write got n=%0d want n=1 data aabbccdd", wr_data.size()); end
    cpu_address = BASE;
    load_valid  = 1'b1;
    load_data   = 8'h5A;
    repeat (3) @(posedge clock);
    #1;
    load_valid = 1'b0;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL bad_stall got %b want 1", cpu_stall); end
    n_checks++; if (cpu_instruction !== 32'd0) begin n_fail++; $display("FAIL bad_instr got %h want 0", cpu_instruction); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL bad_ready got %b want 0", load_ready); end
    n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL bad_error_hold got %b want 1", load_error); end
    n_checks++; if (acc_bytes.size() != s.size()) begin n_fail++; $display("FAIL bad_consumed got %0d want %0d", acc_bytes.size(), s.size()); end
    w = '{$urandom};
    build_stream(w, 1'b0, s, good);
    clear_log();
    pulse_start();
    n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL bad_clear got %b want 0", load_error); end
    send(s, 1'b0, 1'b0, s.size(), ok);
    n_checks++; if (load_done !== 1'b1 || wr_data.size() != 1) begin n_fail++; $display("FAIL bad_reload done=%b n=%0d want done=1 n=1", load_done, wr_data.size()); end
  endtask

  task automatic test_backpressure;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    bit good, ok;
    int unsigned ndiff;
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    build_stream(w, 1'b0, s, good);
    clear_log();
    rdy_in_write = 0;
    pulse_start();
    send(s, 1'b1, 1'b1, s.size(), ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got %0d want 1", ok); end
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", load_done); end
    n_checks++; if (rdy_in_write != 0) begin n_fail++; $display("FAIL bp_ready_in_write got %0d want 0", rdy_in_write); end
    n_checks++; if (wr_addr.size() != 3) begin n_fail++; $display("FAIL bp_nwrites got %0d want 3", wr_addr.size()); end
    for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
      n_checks++; if (wr_addr[i] !== 8'(int'(BASE) + i) || wr_data[i] !== w[i]) begin
        n_fail++; $display("FAIL bp_write[%0d] got %h:%h want %h:%h", i, wr_addr[i], wr_data[i], 8'(int'(BASE) + i), w[i]);
      end
    end
    ndiff = 0;
    foreach (s[i]) if (i >= acc_bytes.size() || acc_bytes[i] !== s[i]) ndiff++;
    n_checks++; if (ndiff != 0 || acc_bytes.size() != s.size()) begin n_fail++; $display("FAIL bp_bytes got n=%0d diffs=%0d want n=%0d diffs=0", acc_bytes.size(), ndiff, s.size()); end
  endtask

  task automatic test_reset_mid_load;
    logic [31:0] w[$];
    logic [7:0]  s[$];
    bit good, ok;
    w = '{$urandom, $urandom};
    build_stream(w, 1'b0, s, good);
    clear_log();
    pulse_start();
    send(s, 1'b0, 1'b0, 3, ok);
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (cpu_stall !== 1'b0 || load_ready !== 1'b0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rst_async_ctl got stall=%b ready=%b we=%b want 0 0 0", cpu_stall, load_ready, mem_we);
    end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_async_wdata got %h want 0", mem_wdata); end
    n_checks++; if (load_done !== 1'b0 || load_error !== 1'b0) begin n_fail++; $display("FAIL rst_async_flags got %b%b want 00", load_done, load_error); end
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL rst_no_write got %0d want 0", wr_addr.size()); end
    w = '{$urandom, $urandom};
    build_stream(w, 1'b0, s, good);
    clear_log();
    pulse_start();
    send(s, 1'b0, 1'b0, s.size(), ok);
    n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL rst_reload_done got %b want 1", load_done); end
    n_checks++; if (wr_data.size() != 2 || wr_data[0] !== w[0] || wr_data[1] !== w[1]) begin
      n_fail++; $display("FAIL rst_reload_writes got n=%0d want 2 words %h %h", wr_data.size(), w[0], w[1]);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    cpu_address = 8'd0;
    load_start  = 1'b0;
    load_data   = 8'd0;
    load_valid  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      exp_mem[i] = ram[i];
    end
    ram[5]     = 32'hDEADBEEF;
    exp_mem[5] = 32'hDEADBEEF;
    #1;
    test_reset();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;
    test_fetch();
    test_single_word();
    test_full_load();
    test_bad_checksum();
    test_backpressure();
    test_reset_mid_load();
    n_checks++; if (instr_nz_stall != 0) begin n_fail++; $display("FAIL stall_nop got %0d nonzero cycles want 0", instr_nz_stall); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
